clk_monitor: RTL and testbench



---
 rtl/clk_monitor_pkg.sv | 29 ++
 rtl/clk_monitor_edge_sync.sv | 30 +++
 rtl/clk_monitor.sv | 146 ++++++++++++++
 tb/tb_clk_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_monitor_pkg.sv
// Shared definitions for the slow-clock monitor: FSM encoding, system clock
// rate and the clog2 helper also used by the clock divider.
`timescale 1ns / 1ps

package clk_monitor_pkg;

  localparam int SYS_HZ = 100_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_monitor_edge_sync.sv
// Two-flop synchroniser plus history flop; rise is high for one system cycle
// per rising edge of din. Also usable for button inputs.
`timescale 1ns / 1ps

module clk_monitor_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_monitor.sv
// Measures the period of a slow asynchronous clock in clk100MHz cycles and
// tracks lock/loss against the expected frequency.
//
// state   | meaning
// IDLE    | after reset, waiting for the first edge
// ACQUIRE | counting consecutive in-window periods
// LOCKED  | LOCK_PERIODS good periods seen, still in window
// LOST    | no edge for TIMEOUT cycles, waiting for the clock to return
`timescale 1ns / 1ps

module clk_monitor
  import clk_monitor_pkg::*;
#(
  parameter  int FREQ_IN      = 100,
  parameter  int TOL_SHIFT    = 4,
  parameter  int LOCK_PERIODS = 4,
  localparam int EXPECTED     = SYS_HZ / FREQ_IN,
  localparam int TIMEOUT      = 2 * EXPECTED,
  localparam int TOL          = EXPECTED >> TOL_SHIFT,
  localparam int PW           = clog2(TIMEOUT)
) (
  input  logic          clk100MHz,
  input  logic          rst,
  input  logic          clk_in,
  output logic          tick,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic          locked,
  output logic          lost
);

  localparam int GW = clog2(LOCK_PERIODS + 1);
  localparam logic [PW-1:0] CNT_MAX = PW'(TIMEOUT - 1);
  localparam logic [PW:0]   WIN_LO  = (PW+1)'(EXPECTED - TOL);
  localparam logic [PW:0]   WIN_HI  = (PW+1)'(EXPECTED + TOL);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_PERIODS);

  logic          e;
  state_t        state;
  state_t        state_next;
  logic [PW-1:0] cnt;
  logic [GW-1:0] good;
  logic [GW-1:0] good_next;
  logic [PW:0]   meas;
  logic          in_win;
  logic          timeout;
  logic          pv;

  clk_monitor_edge_sync u_sync (
    .clk  (clk100MHz),
    .rst  (rst),
    .din  (clk_in),
    .rise (e)
  );

  // One extra bit so an edge at saturation measures TIMEOUT, not a wrap.
  assign meas    = {1'b0, cnt} + (PW+1)'(1);
  assign in_win  = (meas >= WIN_LO) && (meas <= WIN_HI);
  assign timeout = (cnt == CNT_MAX);

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (e) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + PW'(1);
    end
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      good  <= '0;
    end else begin
      state <= state_next;
      good  <= good_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good;
    pv         = 1'b0;
    unique case (state)
      IDLE, LOST: begin
        if (e) begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      ACQUIRE: begin
        if (e) begin
          pv = 1'b1;
          if (!in_win) begin
            good_next = '0;
          end else if (good + GW'(1) == GOOD_LOCK) begin
            state_next = LOCKED;
            good_next  = GOOD_LOCK;
          end else begin
            good_next = good + GW'(1);
          end
        end else if (timeout) begin
          state_next = LOST;
          good_next  = '0;
        end
      end
      LOCKED: begin
        if (e) begin
          pv = 1'b1;
          if (!in_win) begin
            state_next = ACQUIRE;
            good_next  = '0;
          end
        end else if (timeout) begin
          state_next = LOST;
          good_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        good_next  = '0;
      end
    endcase
  end

  // Outputs are flopped from the next-state decode so they line up with tick.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      tick         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      tick         <= e;
      period_valid <= pv;
      if (pv) begin
        period <= meas[PW-1:0];
      end
      locked <= (state_next == LOCKED);
      lost   <= (state_next == LOST);
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor at FREQ_IN=1 MHz (expected period 100 cycles,
// window 94..106, timeout 200, lock after 4 good periods).
`timescale 1ns / 1ps

module tb_clk_monitor;

  logic       clk100MHz;
  logic       rst;
  logic       clk_in;
  logic       tick;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       lost;

  int checks;
  int failures;

  clk_monitor #(
    .FREQ_IN      (1_000_000),
    .TOL_SHIFT    (4),
    .LOCK_PERIODS (4)
  ) dut (
    .clk100MHz    (clk100MHz),
    .rst          (rst),
    .clk_in       (clk_in),
    .tick         (tick),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  initial clk100MHz = 1'b0;
  always #5 clk100MHz = ~clk100MHz;

  initial begin
    #1ms;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk100MHz);
    #1;
  endtask

  // One clk_in period of p cycles starting with a rise; reports what was seen
  // in the first tick cycle.
  task automatic cycle_in(input int p, input int hi, output int tstep, output int tcnt,
                          output logic tpv, output logic [7:0] tper,
                          output logic tlock, output logic tlost);
    tstep = -1;
    tcnt  = 0;
    tpv   = 1'b0;
    tper  = '0;
    tlock = 1'b0;
    tlost = 1'b0;
    clk_in = 1'b1;
    for (int i = 1; i <= p; i++) begin
      if (i == hi + 1) clk_in = 1'b0;
      step();
      if (tick === 1'b1) begin
        tcnt++;
        if (tstep < 0) begin
          tstep = i;
          tpv   = period_valid;
          tper  = period;
          tlock = locked;
          tlost = lost;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    clk_in = 1'b0;
    repeat (3) step();
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
    checks++; if (period !== 8'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL reset_pv got=%b exp=0", period_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%b exp=0", lost); end
    rst = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_acquire_lock(input string tag, input logic from_lost);
    int ts, tc;
    logic tpv, tl, tlo;
    logic [7:0] tp;
    if (from_lost) begin
      checks++; if (lost !== 1'b1) begin failures++; $display("FAIL %s lost_before got=%b exp=1", tag, lost); end
    end
    for (int k = 1; k <= 5; k++) begin
      cycle_in(100, 50, ts, tc, tpv, tp, tl, tlo);
      checks++; if (ts != 3) begin failures++; $display("FAIL %s edge%0d tick_latency got=%0d exp=3", tag, k, ts); end
      checks++; if (tc != 1) begin failures++; $display("FAIL %s edge%0d tick_count got=%0d exp=1", tag, k, tc); end
      checks++; if (tpv !== 1'(k > 1)) begin failures++; $display("FAIL %s edge%0d period_valid got=%b exp=%b", tag, k, tpv, k > 1); end
      if (k > 1) begin
        checks++; if (tp !== 8'd100) begin failures++; $display("FAIL %s edge%0d period got=%0d exp=100", tag, k, tp); end
      end
      checks++; if (tl !== 1'(k == 5)) begin failures++; $display("FAIL %s edge%0d locked got=%b exp=%b", tag, k, tl, k == 5); end
      checks++; if (tlo !== 1'b0) begin failures++; $display("FAIL %s edge%0d lost got=%b exp=0", tag, k, tlo); end
    end
  endtask

  task automatic test_window_bounds();
    int p_tab[8]     = '{94, 106, 93, 100, 100, 100, 100, 100};
    int per_tab[8]   = '{100, 94, 106, 93, 100, 100, 100, 100};
    logic lock_tab[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int ts, tc;
    logic tpv, tl, tlo;
    logic [7:0] tp;
    for (int k = 0; k < 8; k++) begin
      cycle_in(p_tab[k], p_tab[k] / 2, ts, tc, tpv, tp, tl, tlo);
      checks++; if (tpv !== 1'b1) begin failures++; $display("FAIL window%0d period_valid got=%b exp=1", k, tpv); end
      checks++; if (tp !== 8'(per_tab[k])) begin failures++; $display("FAIL window%0d period got=%0d exp=%0d", k, tp, per_tab[k]); end
      checks++; if (tl !== lock_tab[k]) begin failures++; $display("FAIL window%0d locked got=%b exp=%b", k, tl, lock_tab[k]); end
    end
  endtask

  task automatic test_loss();
    int n, k, bad;
    logic found, lock_before;
    clk_in = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 10) begin
      step();
      n++;
      if (tick === 1'b1) found = 1'b1;
    end
    checks++; if (!found || n != 3) begin failures++; $display("FAIL loss_last_tick got=%0d exp=3", n); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL loss_locked_at_tick got=%b exp=1", locked); end
    k = 0;
    lock_before = 1'b0;
    while (lost !== 1'b1 && k < 300) begin
      if (k == 47) clk_in = 1'b0;
      step();
      k++;
      if (k == 199) lock_before = locked;
    end
    checks++; if (k != 200) begin failures++; $display("FAIL loss_latency got=%0d exp=200", k); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL loss_locked got=%b exp=0", locked); end
    checks++; if (lock_before !== 1'b1) begin failures++; $display("FAIL loss_locked_before got=%b exp=1", lock_before); end
    bad = 0;
    repeat (100) begin
      step();
      if (lost !== 1'b1 || locked !== 1'b0 || period_valid !== 1'b0 || tick !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL loss_hold bad_cycles got=%0d exp=0", bad); end
    checks++; if (period !== 8'd100) begin failures++; $display("FAIL loss_period_hold got=%0d exp=100", period); end
  endtask

  task automatic test_out_of_window();
    int ts, tc;
    logic tpv, tl, tlo;
    logic [7:0] tp;
    for (int k = 1; k <= 6; k++) begin
      cycle_in(110, 55, ts, tc, tpv, tp, tl, tlo);
      checks++; if (tpv !== 1'b1) begin failures++; $display("FAIL oow%0d period_valid got=%b exp=1", k, tpv); end
      checks++; if (tp !== ((k == 1) ? 8'd100 : 8'd110)) begin failures++; $display("FAIL oow%0d period got=%0d exp=%0d", k, tp, (k == 1) ? 100 : 110); end
      checks++; if (tl !== 1'(k == 1)) begin failures++; $display("FAIL oow%0d locked got=%b exp=%b", k, tl, k == 1); end
    end
  endtask

  task automatic test_async_reset();
    int ts, tc;
    logic tpv, tl, tlo;
    logic [7:0] tp;
    for (int k = 1; k <= 5; k++) cycle_in(100, 50, ts, tc, tpv, tp, tl, tlo);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL areset_prelock got=%b exp=1", locked); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tick !== 1'b0) begin failures++; $display("FAIL areset_tick got=%b exp=0", tick); end
    checks++; if (period !== 8'd0) begin failures++; $display("FAIL areset_period got=%0d exp=0", period); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL areset_pv got=%b exp=0", period_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL areset_locked got=%b exp=0", locked); end
    checks++; if (lost !== 1'b0) begin failures++; $display("FAIL areset_lost got=%b exp=0", lost); end
    #20;
    rst = 1'b0;
    repeat (5) step();
    test_acquire_lock("post_reset", 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clk_in   = 1'b0;
    test_reset();
    test_acquire_lock("acquire", 1'b0);
    test_window_bounds();
    test_loss();
    test_acquire_lock("recovery", 1'b1);
    test_out_of_window();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
